mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in storage; power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each access; range 0..15.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 reset  input  1: reset is asynchronous and active-low.
REQ-005 mem_read  input  1: read request from the multicycle control unit.
REQ-006 mem_write  input  1: write request from the multicycle control unit.
REQ-007 addr  input  32: byte address (PC or ALUOut, selected upstream by IorD).
REQ-008 wdata  input  32: write data (register B).
REQ-009 rdata  output  32: registered read data.
REQ-010 mem_ready  output  1: one-cycle completion strobe.
REQ-011 busy  output  1: a request is in progress; new requests are ignored.
REQ-012 err  output  1: error qualifier, valid only with mem_ready.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP.
REQ-014 In IDLE, a rising edge with mem_read or mem_write high SHALL latch addr, wdata and the operation, load the wait counter with WAIT_CYCLES, and enter WAIT. That edge is the acceptance edge E0.
REQ-015 If mem_read and mem_write are both high at E0, the operation SHALL be a write.
REQ-016 WAIT SHALL decrement the counter each edge and go to ACCESS on the edge where the counter is 0.
  - With WAIT_CYCLES=0, WAIT lasts one cycle.
REQ-017 ACCESS SHALL perform the array access on its exiting edge and then enter RESP.
  - Write: mem[idx] <= latched wdata.
  - Read: rdata <= mem[idx].
REQ-018 RESP SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE.
  - mem_ready is first high in cycle E0+WAIT_CYCLES+3.
REQ-019 busy SHALL be 1 in WAIT, ACCESS and RESP, and 0 in IDLE.
  - Requests are sampled only in IDLE.
  - Requests asserted while busy are dropped, not queued.
REQ-020 Word index idx SHALL be addr[log2(DEPTH)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-021 rdata SHALL hold its last value until the next read completes.
  - A write SHALL not change rdata.
REQ-022 Back-to-back requests held high SHALL be accepted on the first edge after RESP, i.e. one idle cycle between transactions.

Reset
REQ-023 On reset low, the block SHALL immediately enter IDLE, even mid-operation.
  - mem_ready=0, busy=0, err=0, rdata=0, counter=0.
  - An in-flight write SHALL be abandoned if ACCESS has not completed.
REQ-024 Array contents SHALL NOT be reset.
REQ-025 Release of reset SHALL take effect at the first rising edge with reset high.

Configuration
REQ-026 Macro MEM_ALIGN_CHK_EN defined: a request with latched addr[1:0]!=0 SHALL complete with normal timing but with no array write, rdata unchanged, and err=1 together with mem_ready.
REQ-027 MEM_ALIGN_CHK_EN undefined: addr[1:0] SHALL be ignored and err tied to 0.

Structure
REQ-028 Package mem_resp_pkg SHALL hold the FSM state enum, data and address width constants, and the opcode mapping (rtype, lw, sw, addi, beq, j) shared with the control unit.
REQ-029 Storage SHALL be a sub-module mem_resp_array: synchronous write, registered read, one port.

Verification
REQ-030 Reset low during WAIT of a write to 0x10 -> busy and mem_ready drop immediately; a later read of 0x10 returns its pre-write value.
REQ-031 WAIT_CYCLES=2: write 0xDEADBEEF to 0x08 at E0 -> mem_ready high in cycle E0+5 only; read of 0x08 -> rdata=0xDEADBEEF with mem_ready.
REQ-032 WAIT_CYCLES=0: read of 0x04 -> mem_ready in cycle E0+3; mem_read pulsed during busy -> no second mem_ready.
REQ-033 mem_read and mem_write both high, addr 0x0C, wdata 0x12345678 -> a write occurs and rdata is unchanged; a subsequent read returns 0x12345678.
REQ-034 DEPTH=64: write 0x5A to 0x104 -> a read of 0x004 returns 0x5A (wrap).
REQ-035 MEM_ALIGN_CHK_EN: write to 0x09 -> err=1 with mem_ready and word 0x08 unchanged; without the macro -> word 0x08 is written and err=0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder and the multicycle control unit.
package mem_resp_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle control unit (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mem_ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mem_ready, busy, err
    );

endinterface

// File: rtl/mem_resp_array.sv
// Single-port word storage: synchronous write, registered read that holds until the next read.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Storage is deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for a multicycle CPU: one request at a time, mem_ready strobe on completion.
// Define MEM_ALIGN_CHK_EN to flag misaligned requests with err and suppress their array access.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LA_W  = IDX_W + 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              arr_we, arr_re, misalign;

    // Upper address bits only select outside the array, so they wrap away.
    logic unused_addr;
    assign unused_addr = ^bus.addr[ADDR_W-1:LA_W];

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = (addr_q[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^addr_q[1:0];
    assign misalign   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        arr_we  = 1'b0;
        arr_re  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    addr_d  = bus.addr[LA_W-1:0];
                    wdata_d = bus.wdata;
                    is_wr_d = bus.mem_write;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                arr_we  = is_wr_q && !misalign;
                arr_re  = !is_wr_q && !misalign;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_ready = (state_q == S_RESP);
    assign bus.err       = (state_q == S_RESP) && misalign;

    mem_resp_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .rst_n(reset),
        .we   (arr_we),
        .re   (arr_re),
        .idx  (addr_q[LA_W-1:2]),
        .wdata(wdata_q),
        .rdata(bus.rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder; two instances cover WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int W2    = 2;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if b2 ();
    mem_responder_if b0 ();

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W2)) dut (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );
    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: word array and last read value per instance.
    logic [31:0] mdl_mem [2][DEPTH];
    logic [31:0] mdl_rd  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int s, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (s == 1) begin
            b0.mem_read = rd; b0.mem_write = wr; b0.addr = a; b0.wdata = d;
        end else begin
            b2.mem_read = rd; b2.mem_write = wr; b2.addr = a; b2.wdata = d;
        end
    endtask

    function automatic logic get_ready(input int s);
        return (s == 1) ? b0.mem_ready : b2.mem_ready;
    endfunction
    function automatic logic get_busy(input int s);
        return (s == 1) ? b0.busy : b2.busy;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 1) ? b0.err : b2.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int s);
        return (s == 1) ? b0.rdata : b2.rdata;
    endfunction

    // Apply one accepted request to the model; returns the expected err.
    function automatic bit model_apply(input int s, input bit rd, input bit wr,
                                       input logic [31:0] a, input logic [31:0] d);
        bit mis = ALIGN && (a[1:0] != 2'b00);
        int idx = int'((a >> 2) % DEPTH);
        if (!mis) begin
            if (wr) mdl_mem[s][idx] = d;
            else if (rd) mdl_rd[s] = mdl_mem[s][idx];
        end
        return mis;
    endfunction

    // One full transaction from an idle responder; optionally pulses a request while busy.
    task automatic txn(input int s, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit pulse);
        int w = (s == 1) ? 0 : W2;
        bit exp_err;
        drive(s, rd, wr, a, d);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
        check("busy_after_accept", 32'(get_busy(s)), 32'd1);
        for (int k = 1; k <= w + 3; k++) begin
            if (pulse && k == 1) drive(s, 1'b1, 1'(($urandom_range(1))), $urandom, $urandom);
            @(posedge clk); #1;
            if (pulse && k == 1) drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
            check($sformatf("ready_s%0d_k%0d", s, k), 32'(get_ready(s)), 32'((k == w + 2) ? 1 : 0));
            if (k == w + 2) begin
                exp_err = model_apply(s, rd, wr, a, d);
                check("rdata_at_ready", get_rdata(s), mdl_rd[s]);
                check("err_at_ready", 32'(get_err(s)), 32'(exp_err));
            end
            if (k == w + 3) check("busy_back_idle", 32'(get_busy(s)), 32'd0);
        end
    endtask

    initial begin
        bit e;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        mdl_rd[0] = 32'h0;
        mdl_rd[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", 32'(get_busy(s)), 32'd0);
            check("rst_ready", 32'(get_ready(s)), 32'd0);
            check("rst_err", 32'(get_err(s)), 32'd0);
            check("rst_rdata", get_rdata(s), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Fill both arrays so every later read has a known value.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                txn(s, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Directed cases on the two-wait-state instance.
        txn(0, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
        check("deadbeef_read", get_rdata(0), 32'hDEADBEEF);
        txn(0, 1'b1, 1'b1, 32'h0C, 32'h12345678, 1'b0);
        check("both_high_rdata_kept", get_rdata(0), 32'hDEADBEEF);
        txn(0, 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);
        check("both_high_readback", get_rdata(0), 32'h12345678);
        txn(0, 1'b0, 1'b1, 32'h104, 32'h5A, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
        check("wrap_read", get_rdata(0), 32'h5A);
        txn(0, 1'b0, 1'b1, 32'h09, 32'hA5A5A5A5, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
        check("align_word08", get_rdata(0), ALIGN ? 32'hDEADBEEF : 32'hA5A5A5A5);

        // Reset while a write to 0x10 is waiting: write abandoned, outputs drop at once.
        txn(0, 1'b0, 1'b1, 32'h10, 32'h11111111, 1'b0);
        drive(0, 1'b0, 1'b1, 32'h10, 32'h22222222);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("pre_abort_busy", 32'(get_busy(0)), 32'd1);
        reset = 1'b0;
        #1;
        mdl_rd[0] = 32'h0;
        mdl_rd[1] = 32'h0;
        check("abort_busy", 32'(get_busy(0)), 32'd0);
        check("abort_ready", 32'(get_ready(0)), 32'd0);
        check("abort_rdata", get_rdata(0), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("abort_readback", get_rdata(0), 32'h11111111);

        // Zero-wait instance: read latency and a dropped request while busy.
        txn(1, 1'b0, 1'b1, 32'h04, 32'hCAFEF00D, 1'b0);
        txn(1, 1'b1, 1'b0, 32'h04, 32'h0, 1'b1);
        check("w0_read", get_rdata(1), 32'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("w0_no_second_ready", 32'(get_ready(1)), 32'd0);
        end

        // Request held high: second acceptance one idle cycle after the response.
        drive(0, 1'b1, 1'b0, 32'h0C, 32'h0);
        @(posedge clk); #1;
        for (int k = 1; k <= 2 * W2 + 6; k++) begin
            @(posedge clk); #1;
            if (k == W2 + 4) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            check("b2b_ready", 32'(get_ready(0)), 32'((k == W2 + 2 || k == 2 * W2 + 6) ? 1 : 0));
            if (k == W2 + 3) check("b2b_idle_gap", 32'(get_busy(0)), 32'd0);
            if (k == W2 + 4) check("b2b_reaccept", 32'(get_busy(0)), 32'd1);
            if (k == W2 + 2 || k == 2 * W2 + 6) begin
                e = model_apply(0, 1'b1, 1'b0, 32'h0C, 32'h0);
                check("b2b_rdata", get_rdata(0), mdl_rd[0]);
            end
        end
        @(posedge clk); #1;

        // Randomized traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                int op;
                a = $urandom;
                if ($urandom_range(3) != 0) a[1:0] = 2'b00;
                op = $urandom_range(2);
                txn(s, op != 1, op != 0, a, $urandom, 1'(($urandom_range(1))));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
